// File: rtl/bist_pkg.sv
// Shared definitions for the BIST response analyser: FSM encoding and MISR feedback taps.
package bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Low-order taps of x^(N)+x+1; at WIDTH=5 this zero-extends to 6'b000011.
    localparam logic [1:0] MISR_TAP_LO = 2'b11;

    localparam int CNT_W = 16;
    localparam int FC_W  = 8;

endpackage

// File: rtl/misr_reg.sv
// Multiple-input signature register: shift left, fold msb through the tap mask, xor in data.
import bist_pkg::*;

module misr_reg #(
    parameter int          N    = 6,
    parameter logic [N-1:0] SEED = '0
) (
    input  logic         clk,
    input  logic         load,
    input  logic         en,
    input  logic [N-1:0] data,
    output logic [N-1:0] sig
);

    localparam logic [N-1:0] TAP = N'(MISR_TAP_LO);

    logic [N-1:0] sig_q;
    logic [N-1:0] sig_d;
    logic [N-1:0] shifted;

    always_comb begin
        shifted = {sig_q[N-2:0], 1'b0} ^ (sig_q[N-1] ? TAP : '0);
        sig_d   = sig_q;
        // Load wins so a restart or reset never mixes in a stray sample.
        if (load) begin
            sig_d = SEED;
        end else if (en) begin
            sig_d = shifted ^ data;
        end
    end

    always_ff @(posedge clk) begin
        sig_q <= sig_d;
    end

    assign sig = sig_q;

endmodule

// File: rtl/bist_ora_misr.sv
// BIST output response analyser: compacts adder sum/cout into a MISR and checks against GOLDEN.
// Optional macro ORA_FAIL_COUNT_EN enables the saturating failed-session counter.
import bist_pkg::*;

module bist_ora_misr #(
    parameter int             WIDTH        = 5,
    parameter int             NUM_PATTERNS = 32,
    parameter logic [WIDTH:0] SEED         = '0,
    parameter logic [WIDTH:0] GOLDEN       = '0
) (
    input  logic             clk,
    input  logic             init,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH:0]   signature,
    output logic [FC_W-1:0]  fail_count
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             misr_load;
    logic             misr_en;
    logic [WIDTH:0]   sig;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pass_d    = pass_q;
        misr_load = init;
        misr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    cnt_d     = '0;
                    misr_load = 1'b1;
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    misr_en = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                pass_d  = (sig == GOLDEN);
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    cnt_d     = '0;
                    pass_d    = 1'b0;
                    misr_load = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Status flags are registered against the next state so they line up with it.
        busy_d = (state_d == ST_RUN) || (state_d == ST_CHECK);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (init) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    misr_reg #(
        .N    (WIDTH + 1),
        .SEED (SEED)
    ) u_misr (
        .clk  (clk),
        .load (misr_load),
        .en   (misr_en),
        .data ({cout, sum}),
        .sig  (sig)
    );

`ifdef ORA_FAIL_COUNT_EN
    logic [FC_W-1:0] fc_q, fc_d;

    always_comb begin
        fc_d = fc_q;
        if ((state_q == ST_CHECK) && (sig != GOLDEN) && (fc_q != {FC_W{1'b1}})) begin
            fc_d = fc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            fc_q <= '0;
        end else begin
            fc_q <= fc_d;
        end
    end

    assign fail_count = fc_q;
`else
    assign fail_count = '0;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = sig;

endmodule

// File: tb/tb_bist_ora_misr.sv
// Randomised self-checking bench for bist_ora_misr against a GF(2) polynomial model.
module tb_bist_ora_misr;

    localparam int          W    = 5;
    localparam int          NP   = 4;
    localparam logic [W:0]  SEED = 6'h00;
    localparam logic [W:0]  GOLD = 6'h08;

    logic         clk = 1'b0;
    logic         init, start, in_valid, cout;
    logic [W-1:0] sum;
    logic         busy, done, pass;
    logic [W:0]   signature;
    logic [7:0]   fail_count;

    int n_cmp = 0;
    int n_bad = 0;
    int m_sig;
    int m_fc;
    int q[$];

    bist_ora_misr #(
        .WIDTH        (W),
        .NUM_PATTERNS (NP),
        .SEED         (SEED),
        .GOLDEN       (GOLD)
    ) dut (
        .clk        (clk),
        .init       (init),
        .start      (start),
        .in_valid   (in_valid),
        .sum        (sum),
        .cout       (cout),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .signature  (signature),
        .fail_count (fail_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Signature = signature * x + d over GF(2), reduced mod x^(W+1)+x+1.
    function automatic int mul_x_add(input int s, input int d);
        int r;
        r = s << 1;
        if ((r >> (W + 1)) & 1) r = r ^ ((1 << (W + 1)) | 3);
        return r ^ d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_init();
        init = 1'b1;
        tick();
        init = 1'b0;
        m_sig = SEED;
        m_fc  = 0;
    endtask

    task automatic begin_session(input bit hold_start);
        start = 1'b1;
        tick();
        if (!hold_start) start = 1'b0;
        m_sig = SEED;
        chk("start_busy", busy, 1);
        chk("start_done", done, 0);
        chk("start_pass", pass, 0);
        chk("start_sig", signature, m_sig);
    endtask

    task automatic feed(input int d, input int bubbles);
        in_valid = 1'b1;
        {cout, sum} = (W + 1)'(d);
        tick();
        m_sig = mul_x_add(m_sig, d);
        chk("sample_sig", signature, m_sig);
        in_valid = 1'b0;
        for (int b = 0; b < bubbles; b++) begin
            {cout, sum} = (W + 1)'($urandom);
            tick();
            chk("bubble_sig", signature, m_sig);
            chk("bubble_busy", busy, 1);
        end
    endtask

    // Runs one full session from q; the last sample's edge must lead to CHECK then DONE.
    task automatic run_session(input int bubbles, input bit hold_start);
        begin_session(hold_start);
        for (int i = 0; i < q.size(); i++) begin
            feed(q[i], (i == q.size() - 1) ? 0 : bubbles);
        end
        start = 1'b0;
        chk("check_busy", busy, 1);
        chk("check_done", done, 0);
        tick();
        if (m_sig != GOLD) begin
`ifdef ORA_FAIL_COUNT_EN
            if (m_fc < 255) m_fc++;
`endif
        end
        chk("done_done", done, 1);
        chk("done_busy", busy, 0);
        chk("done_pass", pass, (m_sig == GOLD));
        chk("done_sig", signature, m_sig);
        chk("done_fc", fail_count, m_fc);
    endtask

    initial begin
        init = 1'b0; start = 1'b0; in_valid = 1'b0; sum = '0; cout = 1'b0;
        tick();
        do_init();

        // Init with the FSM in RUN discards everything.
        begin_session(0);
        feed(6'h15, 0);
        do_init();
        chk("rst_sig", signature, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fc", fail_count, 0);

        // IDLE ignores in_valid.
        in_valid = 1'b1;
        {cout, sum} = 6'h3f;
        tick(); tick();
        in_valid = 1'b0;
        chk("idle_sig", signature, SEED);
        chk("idle_busy", busy, 0);

        q = '{0, 0, 0, 0};
        run_session(0, 0);
        chk("zero_sig_const", signature, 6'h00);

        q = '{6'h01, 0, 0, 0};
        run_session(0, 0);
        chk("single_sig_const", signature, 6'h08);
        chk("single_pass_const", pass, 1);

        // DONE holds its results regardless of in_valid.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'($urandom);
            {cout, sum} = (W + 1)'($urandom);
            tick();
            chk("hold_done", done, 1);
            chk("hold_pass", pass, 1);
            chk("hold_sig", signature, 6'h08);
        end
        in_valid = 1'b0;

        // Restart from DONE with bubbles and start held through RUN.
        run_session(2, 1);
        chk("bubble_sig_const", signature, 6'h08);

        q = '{6'h20, 0, 0, 0};
        run_session(0, 0);
        chk("fb_sig_const", signature, 6'h0c);

        // Abort mid-RUN, then a clean session must match the uninterrupted result.
        begin_session(0);
        feed(6'h2a, 0);
        feed(6'h11, 0);
        do_init();
        chk("abort_sig", signature, SEED);
        q = '{6'h01, 0, 0, 0};
        run_session(1, 0);
        chk("abort_rerun_const", signature, 6'h08);

        for (int s = 0; s < 10; s++) begin
            q.delete();
            for (int i = 0; i < NP; i++) q.push_back(int'($urandom_range(0, 63)));
            run_session(int'($urandom_range(0, 3)), 1'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
